// File: rtl/para_ram_clr.sv
// Single-port synchronous RAM with bit-masked writes, 1- or 2-cycle read
// latency with a read-valid strobe, and a post-reset clear sequencer that
// fills every word with CLR_VALUE before requests are accepted.
module para_ram_clr #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  req_drop
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    clr_we;
    logic                    wr_req;
    logic                    rd_req;

    // Merge new data into the stored word only where the mask bit is set.
    function automatic logic [DATA_WIDTH-1:0] merge_masked(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // Requests are honoured only in READY and never while reset is held.
    assign busy    = (state == CLEAR);
    assign clr_we  = !rst && busy;
    assign wr_req  = !rst && !busy && cs && wr_rd;
    assign rd_req  = !rst && !busy && cs && !wr_rd;
    assign rd_word = mem[address];

    // State register; reset always returns to the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Next state: the sweep ends on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    // Clear address walks once through the array; wrapping to 0 at the end
    // leaves it ready for the next sweep and READY never advances it.
    always_ff @(posedge clk) begin
        if (rst)          clr_addr <= '0;
        else if (busy)    clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end

    // Storage: the clear pattern has priority, user writes are masked.
    always_ff @(posedge clk) begin
        if (clr_we)       mem[clr_addr] <= CLR_VALUE;
        else if (wr_req)  mem[address]  <= merge_masked(mem[address], data_in, wr_mask);
    end

    // Any request presented during the sweep is discarded and flagged.
    always_ff @(posedge clk) begin
        if (rst) req_drop <= 1'b0;
        else     req_drop <= cs && busy;
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] word_p0;
            logic                  vld_p0;

            // Stage 0 -> 1: capture the addressed word.
            always_ff @(posedge clk) begin
                if (rd_req) word_p0 <= rd_word;
            end

            // Stage 1 -> output: forward captured word; reset flushes the pipe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p0   <= 1'b0;
                    rd_valid <= 1'b0;
                    data_out <= '0;
                end else begin
                    vld_p0   <= rd_req;
                    rd_valid <= vld_p0;
                    if (vld_p0) data_out <= word_p0;
                end
            end
        end else begin : g_lat1
            // Single stage: addressed word straight to the output register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    data_out <= '0;
                end else begin
                    rd_valid <= rd_req;
                    if (rd_req) data_out <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_para_ram_clr.sv
// Directed bench: two instances share one stimulus stream, one with 1-cycle
// read latency and CLR_VALUE 8'hA5, one with 2-cycle latency and CLR_VALUE 0.
module tb_para_ram_clr;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       wr_rd;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] wr_mask;

    logic [7:0] d1_out, d2_out;
    logic       d1_vld, d2_vld;
    logic       d1_busy, d2_busy;
    logic       d1_drop, d2_drop;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    para_ram_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1), .CLR_VALUE(8'hA5)
    ) u_lat1 (
        .clk(clk), .rst(rst), .cs(cs), .wr_rd(wr_rd), .address(address),
        .data_in(data_in), .wr_mask(wr_mask), .data_out(d1_out),
        .rd_valid(d1_vld), .busy(d1_busy), .req_drop(d1_drop)
    );

    para_ram_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(2), .CLR_VALUE(8'h00)
    ) u_lat2 (
        .clk(clk), .rst(rst), .cs(cs), .wr_rd(wr_rd), .address(address),
        .data_in(data_in), .wr_mask(wr_mask), .data_out(d2_out),
        .rd_valid(d2_vld), .busy(d2_busy), .req_drop(d2_drop)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs    = 1'b0;
        wr_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        cs      = 1'b1;
        wr_rd   = 1'b1;
        address = a;
        data_in = d;
        wr_mask = m;
    endtask

    task automatic rd(input logic [3:0] a);
        cs      = 1'b1;
        wr_rd   = 1'b0;
        address = a;
    endtask

    // Three back-to-back reads (first address in the low nibble), then idle
    // until the 2-cycle instance drains. e1/e2 hold the expected words
    // (first in the low byte) for the latency-1 and latency-2 instances.
    task automatic run_reads(input string tag, input logic [11:0] addrs,
                             input logic [23:0] e1, input logic [23:0] e2);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) rd(addrs[k*4 +: 4]);
            else       idle();
            step();
            check1($sformatf("%s_l1_vld%0d", tag, k), d1_vld, (k < 3));
            check8($sformatf("%s_l1_data%0d", tag, k), d1_out, e1[(k < 3 ? k : 2)*8 +: 8]);
            check1($sformatf("%s_l2_vld%0d", tag, k), d2_vld, (k >= 1 && k < 4));
            if (k >= 1)
                check8($sformatf("%s_l2_data%0d", tag, k), d2_out, e2[(k < 4 ? k - 1 : 2)*8 +: 8]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        idle();
        address = '0;
        data_in = '0;
        wr_mask = '0;
        repeat (3) step();

        // Reset state
        check8("rst_l1_data", d1_out, 8'h00);
        check1("rst_l1_vld",  d1_vld, 1'b0);
        check1("rst_l1_busy", d1_busy, 1'b1);
        check1("rst_l1_drop", d1_drop, 1'b0);
        check8("rst_l2_data", d2_out, 8'h00);
        check1("rst_l2_vld",  d2_vld, 1'b0);
        check1("rst_l2_busy", d2_busy, 1'b1);
        check1("rst_l2_drop", d2_drop, 1'b0);

        // Clear sweep: 16 edges, with a write to addr 5 presented at edge 8
        // (after addr 5 was already cleared) that must be dropped.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) wr(4'd5, 8'h5A, 8'hFF);
            else        idle();
            step();
            check1($sformatf("clr_l1_busy%0d", i), d1_busy, (i < 15));
            check1($sformatf("clr_l2_busy%0d", i), d2_busy, (i < 15));
            check1($sformatf("clr_l1_drop%0d", i), d1_drop, (i == 8));
            check1($sformatf("clr_l2_drop%0d", i), d2_drop, (i == 8));
            check1($sformatf("clr_l1_vld%0d", i),  d1_vld, 1'b0);
            check1($sformatf("clr_l2_vld%0d", i),  d2_vld, 1'b0);
        end

        // Cleared contents at addr 0, 7, 15
        run_reads("clrrd", {4'd15, 4'd7, 4'd0}, {3{8'hA5}}, {3{8'h00}});

        // Masked write, then immediate reads of the same address
        wr(4'd3, 8'hFF, 8'h0F);
        step();
        run_reads("mask", {4'd3, 4'd3, 4'd3}, {3{8'hAF}}, {3{8'h0F}});

        // Zero mask leaves the word alone and produces no read response
        wr(4'd3, 8'h00, 8'h00);
        step();
        check1("mask0_l1_vld", d1_vld, 1'b0);
        check1("mask0_l2_vld", d2_vld, 1'b0);
        run_reads("mask0", {4'd3, 4'd3, 4'd3}, {3{8'hAF}}, {3{8'h0F}});

        // Full-mask writes then back-to-back reads for latency timing
        wr(4'd1, 8'h11, 8'hFF); step();
        wr(4'd2, 8'h22, 8'hFF); step();
        wr(4'd3, 8'h33, 8'hFF); step();
        run_reads("lat", {4'd3, 4'd2, 4'd1}, {8'h33, 8'h22, 8'h11}, {8'h33, 8'h22, 8'h11});

        // cs low with write-looking inputs: nothing happens
        for (int i = 0; i < 10; i++) begin
            cs      = 1'b0;
            wr_rd   = 1'b1;
            address = 4'(i);
            data_in = 8'hEE;
            wr_mask = 8'hFF;
            step();
            check1($sformatf("csl_l1_vld%0d", i),  d1_vld, 1'b0);
            check1($sformatf("csl_l2_vld%0d", i),  d2_vld, 1'b0);
            check1($sformatf("csl_l1_drop%0d", i), d1_drop, 1'b0);
            check1($sformatf("csl_l2_drop%0d", i), d2_drop, 1'b0);
        end
        run_reads("csl_a", {4'd3, 4'd2, 4'd1}, {8'h33, 8'h22, 8'h11}, {8'h33, 8'h22, 8'h11});
        run_reads("csl_b", {4'd9, 4'd5, 4'd0}, {3{8'hA5}}, {3{8'h00}});

        // Reset one edge after a read is issued
        rd(4'd1);
        step();
        check1("mid_l1_vld",  d1_vld, 1'b1);
        check8("mid_l1_data", d1_out, 8'h11);
        check1("mid_l2_vld0", d2_vld, 1'b0);
        rst = 1'b1;
        idle();
        step();
        check1("mid_l2_vld1",  d2_vld, 1'b0);
        check8("mid_l2_data",  d2_out, 8'h00);
        check1("mid_l2_busy",  d2_busy, 1'b1);
        check1("mid_l1_vld1",  d1_vld, 1'b0);
        check8("mid_l1_data1", d1_out, 8'h00);
        check1("mid_l1_busy",  d1_busy, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check1($sformatf("rclr_l1_busy%0d", i), d1_busy, (i < 15));
            check1($sformatf("rclr_l2_busy%0d", i), d2_busy, (i < 15));
            check1($sformatf("rclr_l2_vld%0d", i),  d2_vld, 1'b0);
        end
        run_reads("rclr", {4'd3, 4'd2, 4'd1}, {3{8'hA5}}, {3{8'h00}});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/para_ram_clr.md
Name: para_ram_clr

Overview:
- Parametrised single-port synchronous RAM with chip select and a combined write/read strobe (`wr_rd`).
- Adds bit-masked writes and a selectable read latency of 1 or 2 cycles with a read-valid strobe.
- Adds a hardware clear sequencer that writes CLR_VALUE to every location after reset.
- Serves as the general-purpose scratch/parameter memory for datapath blocks that must start from a known memory image.

Parameters:
- DATA_WIDTH, 8, word width in bits (≥1).
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, cycles from read request to data_out/rd_valid; legal values 1 or 2 only.
- CLR_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear sequence.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select; a request exists only when cs=1.
- wr_rd  input  1  1 = write, 0 = read (qualified by cs).
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- wr_mask  input  DATA_WIDTH  per-bit write enable; 1 = bit updated.
- data_out  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse, coincident with new data_out.
- busy  output  1  high while the clear sequence runs; requests are not accepted.
- req_drop  output  1  one-cycle pulse: cs=1 was presented while busy=1 and the request was discarded.

Behaviour:
- Reset values: data_out=0, rd_valid=0, busy=1, req_drop=0, FSM=CLEAR, clr_addr=0, read pipeline empty. Memory contents are not reset directly.
- FSM states:
  - CLEAR: while rst=0, each cycle write CLR_VALUE to memory[clr_addr], then clr_addr++.
  - Leave CLEAR for READY on the edge that writes address DEPTH-1.
  - While rst=1, stay in CLEAR with clr_addr held at 0.
  - READY: serve requests; leave only via rst.
- Busy timing: busy=1 during CLEAR and goes 0 on the edge that writes DEPTH-1. After rst falls, busy is high for exactly DEPTH cycles (default 16).
- Write (READY, cs=1, wr_rd=1): memory[address] <= (memory[address] & ~wr_mask) | (data_in & wr_mask). wr_mask=0 leaves the word unchanged. No read response.
- Read (READY, cs=1, wr_rd=0):
  - RD_LATENCY=1: data_out <= memory[address] on the same edge; rd_valid=1 for the following cycle.
  - RD_LATENCY=2: memory word captured in a stage register, then moved to data_out one edge later; rd_valid is pipelined to match.
  - Back-to-back reads are accepted every cycle with full throughput.
- data_out holds its last value when no read completes; rd_valid=0 in those cycles.
- Read after write to the same address on the next cycle returns the new (masked) data.
- Within one edge, a read returns pre-write contents only if a write occurred on the same edge. This cannot happen: the port is single, so one op per cycle.
- cs=0: no memory access, no pulses. wr_rd and address are ignored.
- cs=1 while busy: no memory access and no read response; req_drop=1 for the next cycle. A write during CLEAR never corrupts the clear pattern.
- rst mid-operation: in-flight reads are cancelled (rd_valid never asserts for them), data_out=0, and the clear restarts from address 0. The clear itself overwrites all words.
- Address arithmetic: clr_addr is ADDR_WIDTH+1 wide or compared to DEPTH-1; no wrap into a second sweep.

Test Plan:
- Reset then clear: rst high 3 cycles, CLR_VALUE=8'hA5 → busy=1 for 16 cycles after release, then 0. Reads of addr 0, 7, 15 return 8'hA5 with rd_valid pulsing once each.
- Masked write: write addr 3 data 8'hFF mask 8'h0F over cleared 8'h00, then read addr 3 → data_out=8'h0F. Write data 8'h00 mask 8'h00 → word unchanged.
- Latency: RD_LATENCY=2, reads of addrs 1,2,3 on consecutive cycles (after writing 8'h11, 8'h22, 8'h33) → rd_valid high on cycles +2,+3,+4 with data 8'h11, 8'h22, 8'h33. RD_LATENCY=1 → cycles +1,+2,+3.
- Busy rejection: write addr 5 data 8'h5A during the clear → req_drop pulses once. After clear, read addr 5 → CLR_VALUE, not 8'h5A.
- Reset mid-read: RD_LATENCY=2, read issued, rst asserted next edge → rd_valid stays 0, data_out=0, busy=1, and a full 16-cycle clear follows.
- cs low: cs=0 with wr_rd=1 and data 8'hEE for 10 cycles → all words retain prior values, rd_valid=0, req_drop=0.
